// File: rtl/state_lane_memory.sv
// Lane memory with single-lane write, one-cycle bulk load, and a
// valid/ready dump port that streams every lane in order with contents frozen.
module state_lane_memory #(
  parameter int LANE_W = 25,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [LANE_W*DEPTH-1:0] init_data,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       page,
  input  logic [LANE_W-1:0]       data,
  output logic [LANE_W-1:0]       out,
  input  logic                    save,
  input  logic                    dump_ready,
  output logic                    dump_valid,
  output logic [ADDR_W-1:0]       dump_addr,
  output logic [LANE_W-1:0]       dump_data,
  output logic                    busy
);

  typedef enum logic {S_IDLE, S_DUMP} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [LANE_W-1:0] r_lane [DEPTH];

  logic w_page_ok, w_idle, w_do_load, w_do_save, w_do_write;

  // A full power-of-two address space has no out-of-range pages.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full
      assign w_page_ok = 1'b1;
    end else begin : g_part
      assign w_page_ok = int'(page) < DEPTH;
    end
  endgenerate

  assign w_idle     = (r_state == S_IDLE);
  assign w_do_load  = w_idle & load;
  assign w_do_save  = w_idle & ~load & save;
  assign w_do_write = w_idle & ~load & ~save & write & w_page_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE: if (w_do_save) w_state_nxt = S_DUMP;
      S_DUMP: if (dump_ready) begin
        if (r_addr == LAST) begin
          w_state_nxt = S_IDLE;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt = r_addr + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_lane[k] <= '0;
    end else if (w_do_load) begin
      for (int k = 0; k < DEPTH; k++) r_lane[k] <= init_data[k*LANE_W +: LANE_W];
    end else if (w_do_write) begin
      r_lane[page] <= data;
    end
  end

  // r_addr is held at 0 outside a dump, so dump_data reads lane 0 then.
  assign out        = w_page_ok ? r_lane[page] : '0;
  assign busy       = (r_state == S_DUMP);
  assign dump_valid = busy;
  assign dump_addr  = r_addr;
  assign dump_data  = r_lane[r_addr];

endmodule

// File: tb/tb_state_lane_memory.sv
// Bench for state_lane_memory: directed table, corner-case sequences and
// random traffic against a queue-based reference model.
module tb_state_lane_memory;
  localparam int LANE_W = 25;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0, load = 1'b0, write = 1'b0, save = 1'b0, dump_ready = 1'b0;
  logic [LANE_W*DEPTH-1:0] init_data = '0;
  logic [ADDR_W-1:0]       page = '0;
  logic [LANE_W-1:0]       data = '0;
  logic [LANE_W-1:0]       out, dump_data;
  logic                    dump_valid, busy;
  logic [ADDR_W-1:0]       dump_addr;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lane array plus a queue of lane indices still to be dumped.
  logic [LANE_W-1:0] m_lane [DEPTH];
  int                m_q [$];

  state_lane_memory #(.LANE_W(LANE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .init_data(init_data), .write(write),
    .page(page), .data(data), .out(out), .save(save), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_init(input int sel);
    for (int k = 0; k < DEPTH; k++)
      init_data[k*LANE_W +: LANE_W] = (sel == 1) ? LANE_W'(k*3 + 7) :
                                      (sel == 2) ? LANE_W'($urandom) : LANE_W'(k);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) m_lane[k] = '0;
      m_q.delete();
    end else if (m_q.size() > 0) begin
      if (dump_ready) void'(m_q.pop_front());
    end else if (load) begin
      for (int k = 0; k < DEPTH; k++) m_lane[k] = init_data[k*LANE_W +: LANE_W];
    end else if (save) begin
      for (int k = 0; k < DEPTH; k++) m_q.push_back(k);
    end else if (write && int'(page) < DEPTH) begin
      m_lane[page] = data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    logic act_v;
    #1;
    act_v = (m_q.size() > 0);
    cmp("out", 32'(out), (int'(page) < DEPTH) ? 32'(m_lane[page]) : 32'd0);
    cmp("busy", 32'(busy), 32'(act_v));
    cmp("dump_valid", 32'(dump_valid), 32'(act_v));
    cmp("dump_addr", 32'(dump_addr), act_v ? 32'(m_q[0]) : 32'd0);
    cmp("dump_data", 32'(dump_data), act_v ? 32'(m_lane[m_q[0]]) : 32'(m_lane[0]));
  endtask

  task automatic drain_dump();
    int cyc = 0;
    save = 0; load = 0; write = 0; dump_ready = 1;
    while (busy === 1'b1 && cyc < 200) begin tick(); cyc++; end
    cmp("drain_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    bit rst_n, load, save, write;
    int init_sel;
    logic [ADDR_W-1:0] page;
    logic [LANE_W-1:0] data;
    logic [LANE_W-1:0] exp_out;
    bit exp_busy;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int cnt, cyc;
    logic have_prev;
    logic [ADDR_W-1:0] prev_addr;
    logic [LANE_W-1:0] prev_data;
    bit pat [4];

    // Reset then sweep every page.
    rst_n = 0; tick(); rst_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      page = ADDR_W'(i); #1;
      cmp("reset_out", 32'(out), 32'd0);
      cmp("reset_busy", 32'(busy), 32'd0);
    end

    vecs[0]  = '{0,0,0,0, 0,  7, 0,          0,          0};
    vecs[1]  = '{0,1,0,0, 0,  9, 0,          0,          0};
    vecs[2]  = '{1,1,0,0, 0,  5, 0,          5,          0};
    vecs[3]  = '{1,0,0,1, 0,  5, 25'h1ABCDEF, 25'h1ABCDEF, 0};
    vecs[4]  = '{1,0,0,0, 0,  6, 0,          6,          0};
    vecs[5]  = '{1,1,1,1, 1,  3, 25'h123,    16,         0};
    vecs[6]  = '{1,0,0,0, 1,  3, 0,          16,         0};
    vecs[7]  = '{1,0,0,1, 1, 63, 25'h1FFFFFF, 25'h1FFFFFF, 0};
    vecs[8]  = '{1,0,0,0, 1,  0, 0,          7,          0};
    vecs[9]  = '{0,0,0,1, 1, 63, 5,          0,          0};
    vecs[10] = '{1,0,0,0, 1, 63, 0,          0,          0};
    dump_ready = 1;
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; load = vecs[i].load; save = vecs[i].save;
      write = vecs[i].write; page = vecs[i].page; data = vecs[i].data;
      set_init(vecs[i].init_sel);
      tick();
      load = 0; save = 0; write = 0; rst_n = 1; #1;
      cmp($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
      cmp($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
    end

    // Full dump with dump_ready held high, then back-to-back save.
    set_init(0); load = 1; tick(); load = 0;
    save = 1; tick(); save = 0; dump_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      page = ADDR_W'(i); #1;
      cmp("full_valid", 32'(dump_valid), 32'd1);
      cmp("full_addr", 32'(dump_addr), 32'(i));
      cmp("full_data", 32'(dump_data), 32'(i));
      tick();
    end
    save = 1; #1;
    cmp("full_end_busy", 32'(busy), 32'd0);
    cmp("full_end_valid", 32'(dump_valid), 32'd0);
    tick(); save = 0; #1;
    cmp("b2b_busy", 32'(busy), 32'd1);
    cmp("b2b_addr", 32'(dump_addr), 32'd0);
    drain_dump();

    // Backpressure with a write to lane 0 attempted throughout the dump.
    set_init(1); load = 1; tick(); load = 0;
    save = 1; tick(); save = 0;
    write = 1; page = 0; data = 25'h0AAAAAA;
    pat = '{1, 0, 0, 1};
    cnt = 0; cyc = 0; have_prev = 0; prev_addr = '0; prev_data = '0;
    while (cnt < DEPTH && cyc < 400) begin
      dump_ready = pat[cyc % 4]; #1;
      cmp("bp_valid", 32'(dump_valid), 32'd1);
      cmp("bp_out_lane0", 32'(out), 32'd7);
      if (have_prev) begin
        cmp("bp_hold_addr", 32'(dump_addr), 32'(prev_addr));
        cmp("bp_hold_data", 32'(dump_data), 32'(prev_data));
      end
      cmp("bp_addr", 32'(dump_addr), 32'(cnt));
      cmp("bp_data", 32'(dump_data), 32'(cnt*3 + 7));
      have_prev = !dump_ready; prev_addr = dump_addr; prev_data = dump_data;
      if (dump_ready) cnt++;
      tick(); cyc++;
    end
    write = 0; dump_ready = 0;
    cmp("bp_beats", 32'(cnt), 32'(DEPTH));
    #1;
    cmp("bp_busy_end", 32'(busy), 32'd0);
    cmp("bp_lane0_kept", 32'(out), 32'd7);

    // Reset at beat 10 aborts the dump; next dump streams zeros from 0.
    save = 1; tick(); save = 0; dump_ready = 1; cyc = 0;
    #1;
    while (dump_addr !== 6'd10 && cyc < 100) begin tick(); cyc++; end
    cmp("mid_reach10", 32'(dump_addr), 32'd10);
    rst_n = 0; tick(); rst_n = 1; #1;
    cmp("mid_valid", 32'(dump_valid), 32'd0);
    cmp("mid_busy", 32'(busy), 32'd0);
    cmp("mid_addr", 32'(dump_addr), 32'd0);
    cmp("mid_data", 32'(dump_data), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      page = ADDR_W'(i); #1;
      cmp("mid_lane_zero", 32'(out), 32'd0);
    end
    save = 1; tick(); save = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      cmp("re_addr", 32'(dump_addr), 32'(i));
      cmp("re_data", 32'(dump_data), 32'd0);
      tick();
    end
    #1;
    cmp("re_busy_end", 32'(busy), 32'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      load       = ($urandom_range(0, 15) == 0);
      save       = ($urandom_range(0, 9) == 0);
      write      = $urandom_range(0, 1) == 1;
      page       = ADDR_W'($urandom);
      data       = LANE_W'($urandom);
      dump_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) set_init(2);
      check_model();
      tick();
    end
    rst_n = 1; load = 0; save = 0; write = 0;
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
